// File: rtl/hwpf_req_issuer.sv
// hwpf_req_issuer: pops next-line prefetch candidates from the request stack,
// aligns them to cache lines, drops lines that are already in flight and issues
// the rest over a valid/ready request port. Each issued line occupies one slot
// until its response returns with the matching ID.
module hwpf_req_issuer #(
    parameter int ADDR_WIDTH       = 40,
    parameter int LINE_OFFSET_BITS = 6,
    parameter int NUM_INFLIGHT     = 4,
    parameter int ID_WIDTH         = $clog2(NUM_INFLIGHT)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  stack_valid_i,
    input  logic [ADDR_WIDTH-1:0] stack_req_i,
    output logic                  stack_pop_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [ID_WIDTH-1:0]   mem_req_id_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [ID_WIDTH-1:0]   mem_rsp_id_i,
    output logic                  dropped_o,
    output logic                  busy_o
);

    localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET_BITS;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic [NUM_INFLIGHT-1:0] r_slot_valid;
    logic [NUM_INFLIGHT-1:0] w_slot_valid_nxt;
    logic [LINE_W-1:0]       r_slot_line [NUM_INFLIGHT];
    logic [LINE_W-1:0]       r_req_line;
    logic [ID_WIDTH-1:0]     r_req_id;
    logic                    r_dropped;
    logic                    r_busy;

    logic [LINE_W-1:0]       w_cand_line;
    logic [ID_WIDTH-1:0]     w_free_idx;
    logic                    w_any_free;
    logic                    w_dup;
    logic                    w_pop;
    logic                    w_alloc;
    logic                    w_unused_offset;

    // The byte offset inside the line never matters for prefetching.
    assign w_cand_line     = stack_req_i[ADDR_WIDTH-1:LINE_OFFSET_BITS];
    assign w_unused_offset = ^stack_req_i[LINE_OFFSET_BITS-1:0];

    // Lowest-index free slot, taken from the registered valid vector so a slot
    // released by a response this cycle is only reusable next cycle.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write so
        // no path leaves it unassigned and no latch is inferred.
        w_free_idx = '0;
        w_any_free = 1'b0;
        for (int i = NUM_INFLIGHT - 1; i >= 0; i--) begin
            if (!r_slot_valid[i]) begin
                w_free_idx = ID_WIDTH'(i);
                w_any_free = 1'b1;
            end
        end
    end

    // Candidate line already tracked by a valid slot.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < NUM_INFLIGHT; i++) begin
            if (r_slot_valid[i] && (r_slot_line[i] == w_cand_line)) begin
                w_dup = 1'b1;
            end
        end
    end

    // Pop only from IDLE; there is deliberately no path from mem_req_ready_i.
    assign w_pop   = (r_state == ST_IDLE) & enable_i & ~flush_i & stack_valid_i & w_any_free;
    assign w_alloc = w_pop & ~w_dup;

    // Slot table update: responses release, a non-duplicate pop reserves.
    always_comb begin
        w_slot_valid_nxt = r_slot_valid;
        // Clearing an already-free slot is a no-op, which ignores stray responses.
        if (mem_rsp_valid_i) begin
            w_slot_valid_nxt[mem_rsp_id_i] = 1'b0;
        end
        // The reserved slot was free, so it can never collide with a live response.
        if (w_alloc) begin
            w_slot_valid_nxt[w_free_idx] = 1'b1;
        end
    end

    // FSM: IDLE waits for a fresh line, ISSUE holds the request until accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_alloc)         w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (mem_req_ready_i) w_state_nxt = ST_IDLE;
            default:                       w_state_nxt = ST_IDLE;
        endcase
    end

    // Control state, request register and status flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= ST_IDLE;
            r_slot_valid <= '0;
            r_req_line   <= '0;
            r_req_id     <= '0;
            r_dropped    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            r_state      <= w_state_nxt;
            r_slot_valid <= w_slot_valid_nxt;
            r_dropped    <= w_pop & w_dup;
            r_busy       <= (w_state_nxt == ST_ISSUE) | (|w_slot_valid_nxt);
            if (w_alloc) begin
                r_req_line <= w_cand_line;
                r_req_id   <= w_free_idx;
            end
        end
    end

    // Slot line storage.
    always_ff @(posedge clk_i) begin
        // NOTE: no reset here; a line is only ever compared while its valid
        // bit is set, and the valid bits are reset.
        if (w_alloc) begin
            r_slot_line[w_free_idx] <= w_cand_line;
        end
    end

    assign stack_pop_o     = w_pop;
    assign mem_req_valid_o = (r_state == ST_ISSUE);
    assign mem_req_addr_o  = {r_req_line, {LINE_OFFSET_BITS{1'b0}}};
    assign mem_req_id_o    = r_req_id;
    assign dropped_o       = r_dropped;
    assign busy_o          = r_busy;

endmodule
